// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: turns the FIFO empty/increment interface into a registered valid/ready sample stream.
// It has a 2-entry skid buffer and frame tagging. Optional macro FIFO_RD_STATS_EN adds the o_starve_cnt counter.
`default_nettype none

module fifo_rd_ctrl #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic              i_rd_clk,
  input  logic              i_rdrst_n,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_rd_inc,
  input  logic              i_enable,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
`ifdef FIFO_RD_STATS_EN
  output logic [15:0]       o_starve_cnt,
`endif
  output logic              o_frame_done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              head_last_q, head_last_d;
  logic              tail_last_q, tail_last_d;
  logic              frame_done_q, frame_done_d;

  logic              deq;
  logic              pop;
  logic              new_last;
  logic [1:0]        rem;

  always_comb begin
    deq      = (cnt_q != 2'd0) & i_ready;
    rem      = cnt_q - {1'b0, deq};
    pop      = i_rdrst_n & i_enable & ~i_fifo_empty & ~i_flush & (rem < 2'd2);
    new_last = (fcnt_q == LAST_IDX);

    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    head_data_d  = head_data_q;
    head_last_d  = head_last_q;
    tail_data_d  = tail_data_q;
    tail_last_d  = tail_last_q;
    frame_done_d = 1'b0;

    if (i_flush) begin
      cnt_d       = 2'd0;
      fcnt_d      = '0;
      head_data_d = '0;
      head_last_d = 1'b0;
      tail_data_d = '0;
      tail_last_d = 1'b0;
    end else begin
      cnt_d        = rem + {1'b0, pop};
      frame_done_d = deq & head_last_q;
      // A dequeue from a full buffer promotes the tail entry to the head.
      if (deq && (cnt_q == 2'd2)) begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
      end
      if (pop) begin
        fcnt_d = new_last ? '0 : fcnt_q + CNT_W'(1);
        if (rem == 2'd0) begin
          head_data_d = i_fifo_data;
          head_last_d = new_last;
        end else begin
          tail_data_d = i_fifo_data;
          tail_last_d = new_last;
        end
      end
    end
  end

  always_ff @(posedge i_rd_clk) begin
    if (!i_rdrst_n) begin
      cnt_q        <= 2'd0;
      fcnt_q       <= '0;
      head_data_q  <= '0;
      head_last_q  <= 1'b0;
      tail_data_q  <= '0;
      tail_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      head_data_q  <= head_data_d;
      head_last_q  <= head_last_d;
      tail_data_q  <= tail_data_d;
      tail_last_q  <= tail_last_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (i_flush) begin
      starve_d = 16'h0;
    end else if (i_ready && (cnt_q == 2'd0) && i_enable && (starve_q != 16'hFFFF)) begin
      starve_d = starve_q + 16'd1;
    end
  end

  always_ff @(posedge i_rd_clk) begin
    if (!i_rdrst_n) begin
      starve_q <= 16'h0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign o_starve_cnt = starve_q;
`endif

  assign o_rd_inc     = pop;
  assign o_valid      = (cnt_q != 2'd0);
  assign o_data       = head_data_q;
  assign o_last       = head_last_q;
  assign o_frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized self-checking bench for fifo_rd_ctrl.
// It uses a queue-based FIFO and a tagged-sample reference model.
`default_nettype none

module tb_fifo_rd_ctrl;
  localparam int DW = 16;
  localparam int FL = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          rd_inc;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          valid;
  logic [DW-1:0] data;
  logic          last;
  logic          ready = 1'b0;
  logic          frame_done;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]   starve_cnt;
`endif

  fifo_rd_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .i_rd_clk     (clk),
    .i_rdrst_n    (rst_n),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_rd_inc     (rd_inc),
    .i_enable     (enable),
    .i_flush      (flush),
    .o_valid      (valid),
    .o_data       (data),
    .o_last       (last),
    .i_ready      (ready),
`ifdef FIFO_RD_STATS_EN
    .o_starve_cnt (starve_cnt),
`endif
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } ent_t;

  logic [DW-1:0] fifo_q[$];
  ent_t          exp_q[$];
  int            fm = 0;
  bit            fd_pend = 0;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  logic          s_rd_inc, s_valid, s_last, s_fdone;
  logic [DW-1:0] s_data;
  logic          e_rd_inc, e_valid, e_last, e_fdone;
  logic [DW-1:0] e_data;

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
  endtask

  task automatic fifo_load(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
    fifo_refresh();
  endtask

  // Sample the DUT mid-cycle, predict from the queue model, then advance one edge.
  task automatic tick();
    bit deq;
    @(negedge clk);
    #1;
    s_rd_inc = rd_inc; s_valid = valid; s_data = data; s_last = last; s_fdone = frame_done;
    e_valid  = (exp_q.size() != 0);
    e_data   = e_valid ? exp_q[0].d : '0;
    e_last   = e_valid ? exp_q[0].l : 1'b0;
    e_fdone  = fd_pend;
    deq      = e_valid && ready;
    e_rd_inc = rst_n && enable && !fifo_empty && !flush && ((exp_q.size() - int'(deq)) < 2);
    if (!rst_n || flush) begin
      exp_q.delete();
      fm = 0;
      fd_pend = 0;
    end else begin
      fd_pend = deq && e_last;
      if (deq) void'(exp_q.pop_front());
      if (e_rd_inc) begin
        exp_q.push_back({fifo_q[0], fm == FL - 1});
        void'(fifo_q.pop_front());
        fm = (fm + 1) % FL;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    fifo_refresh();
  endtask

  function automatic logic [DW+3:0] obs_vec();
    return {s_rd_inc, s_valid, s_valid ? s_data : DW'(0), s_valid & s_last, s_fdone};
  endfunction

  function automatic logic [DW+3:0] exp_vec();
    return {e_rd_inc, e_valid, e_data, e_last, e_fdone};
  endfunction

  task automatic test_reset();
    int pops = 0;
    logic [5:0] pm = '0, vm = '0;
    rst_n = 0; enable = 1; ready = 1; flush = 0;
    fifo_load(3);
    tick();
    repeat (2) begin
      tick();
      checks++;
      if ({s_rd_inc, s_valid, s_data, s_last, s_fdone} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got rd_inc=%b valid=%b data=%h last=%b fdone=%b want all 0",
                 s_rd_inc, s_valid, s_data, s_last, s_fdone);
      end
    end
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_stream cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      pm[i] = s_rd_inc; vm[i] = s_valid;
      pops += int'(s_rd_inc);
    end
    checks++;
    if (pm !== 6'b000111 || pops != 3) begin
      errors++;
      $display("FAIL reset_pops got pattern=%b want=000111", pm);
    end
    checks++;
    if (vm !== 6'b001110) begin
      errors++;
      $display("FAIL reset_valid got pattern=%b want=001110", vm);
    end
  endtask

  task automatic test_backpressure();
    int pops = 0, acc = 0;
    enable = 1; ready = 0;
    fifo_load(10);
    repeat (6) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      pops += int'(s_rd_inc);
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL bp_pops got=%0d want=2", pops);
    end
    ready = 1;
    repeat (16) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      acc += int'(s_valid);
    end
    checks++;
    if (acc != 10) begin
      errors++;
      $display("FAIL bp_count got=%0d want=10", acc);
    end
  endtask

  task automatic test_frame();
    int idx = 0, fds = 0;
    logic [15:0] lm = '0;
    flush = 1;
    tick();
    flush = 0; ready = 1; enable = 1;
    fifo_load(9);
    repeat (14) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL frame_stream cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (s_valid) begin
        idx++;
        if (s_last) lm[idx] = 1'b1;
      end
      fds += int'(s_fdone);
    end
    checks++;
    if (lm !== 16'h0110 || idx != 9) begin
      errors++;
      $display("FAIL frame_last got mask=%h count=%0d want mask=0110 count=9", lm, idx);
    end
    checks++;
    if (fds != 2) begin
      errors++;
      $display("FAIL frame_done_count got=%0d want=2", fds);
    end
  endtask

  task automatic test_pause();
    int pops = 0;
    enable = 1; ready = 0;
    fifo_load(10);
    repeat (3) tick();
    enable = 0; ready = 1;
    repeat (5) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pause_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      pops += int'(s_rd_inc);
    end
    checks++;
    if (pops != 0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL pause_idle got pops=%0d valid=%b want pops=0 valid=0", pops, s_valid);
    end
    enable = 1;
    repeat (12) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pause_resume cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    int idx = 0, first_last = 0;
    flush = 1;
    tick();
    flush = 0; enable = 1; ready = 1;
    fifo_load(10);
    repeat (2) tick();
    ready = 0;
    tick();
    flush = 1;
    tick();
    checks++;
    if (s_rd_inc !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_pop got rd_inc=%b want=0", s_rd_inc);
    end
    flush = 0; ready = 1;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_data !== '0) begin
      errors++;
      $display("FAIL flush_clear got valid=%b data=%h want valid=0 data=0", s_valid, s_data);
    end
    repeat (14) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL flush_stream cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (s_valid) begin
        idx++;
        if (s_last && first_last == 0) first_last = idx;
      end
    end
    checks++;
    if (first_last != FL) begin
      errors++;
      $display("FAIL flush_frame got first last at=%0d want=%0d", first_last, FL);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(7) != 0);
      ready  = ($urandom_range(2) != 0);
      flush  = ($urandom_range(39) == 0);
      if (fifo_q.size() < 3 && $urandom_range(3) == 0) fifo_load($urandom_range(6, 1));
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    enable = 1; ready = 1; flush = 0;
    repeat (20) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    enable = 0; ready = 1;
    fifo_q.delete();
    fifo_refresh();
    repeat (4) tick();
    flush = 1;
    tick();
    flush = 0; enable = 1;
    repeat (20) tick();
    checks++;
    if (starve_cnt !== 16'd20) begin
      errors++;
      $display("FAIL starve_count got=%0d want=20", starve_cnt);
    end
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (starve_cnt !== 16'd0) begin
      errors++;
      $display("FAIL starve_flush got=%0d want=0", starve_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_backpressure();
    test_frame();
    test_pause();
    test_flush();
    test_random();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
